// File: rtl/rsa_cmd_pkg.sv
// Shared constants for the RSA command bridge: opcodes, FSM states and command field layout.
package rsa_cmd_pkg;

  localparam logic [3:0] OP_COMPUTE = 4'd0;
  localparam logic [3:0] OP_LOAD    = 4'd1;
  localparam logic [3:0] OP_READ    = 4'd2;

  // Encodings are visible to software through the leds port.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StStart  = 3'd2,
    StWait   = 3'd3,
    StUnload = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam int unsigned CmdOpLsb   = 0;
  localparam int unsigned CmdOpW     = 4;
  localparam int unsigned CmdSlotLsb = 4;
  localparam int unsigned CmdSlotW   = 4;
  localparam int unsigned CmdTLsb    = 22;
  localparam int unsigned CmdTW      = 10;

endpackage

// File: rtl/rsa_result_serializer.sv
// Streams an OPW-bit result out as BUSW-wide beats, least-significant chunk first.
module rsa_result_serializer #(
  parameter int unsigned OPW  = 1024,
  parameter int unsigned BUSW = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            active_i,
  input  logic [OPW-1:0]  result_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [BUSW-1:0] out_data_o,
  output logic            last_o
);

  localparam int unsigned NBeat = OPW / BUSW;
  localparam int unsigned BeatW = (NBeat > 1) ? $clog2(NBeat) : 1;

  logic [BeatW-1:0]            beat_q, beat_d;
  logic [NBeat-1:0][BUSW-1:0]  chunks;
  logic                        fire, is_last;

  assign chunks      = result_i;
  assign out_valid_o = active_i;
  assign out_data_o  = chunks[beat_q];
  assign fire        = active_i & out_ready_i;
  assign is_last     = (beat_q == BeatW'(NBeat - 1));
  assign last_o      = fire & is_last;

  // Next beat: restart on clear, advance on each accepted beat, wrap after the last.
  always_comb begin
    beat_d = beat_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (fire) begin
      beat_d = is_last ? '0 : beat_q + 1'b1;
    end
  end

  // Beat counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) beat_q <= '0;
    else       beat_q <= beat_d;
  end

endmodule

// File: rtl/rsa_cmd_bridge.sv
// Host command bridge: decodes commands, loads operand slots in beats, runs the
// exponentiation core and streams its result back.
module rsa_cmd_bridge
  import rsa_cmd_pkg::*;
#(
  parameter int unsigned OPW   = 1024,
  parameter int unsigned BUSW  = 256,
  parameter int unsigned NSLOT = 5,
  parameter int unsigned TW    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          cmd,
  input  logic                 cmd_valid,
  output logic                 done,
  input  logic                 done_read,
  output logic                 err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUSW-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUSW-1:0]      out_data,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic [OPW-1:0]       core_result,
  output logic [NSLOT*OPW-1:0] operands,
  output logic [TW-1:0]        core_t,
  output logic [3:0]           leds
);

  localparam int unsigned NBeat = OPW / BUSW;
  localparam int unsigned BeatW = (NBeat > 1) ? $clog2(NBeat) : 1;
  localparam int unsigned SlotW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  state_e                               state_q, state_d;
  logic [BeatW-1:0]                     ld_beat_q, ld_beat_d;
  logic [SlotW-1:0]                     slot_q, slot_d;
  logic [NSLOT-1:0][NBeat-1:0][BUSW-1:0] ops_q, ops_d;
  logic [OPW-1:0]                       result_q, result_d;
  logic [TW-1:0]                        core_t_q, core_t_d;
  logic                                 err_q, err_d;
  logic                                 ser_clear, ser_last, load_fire;

  logic [CmdOpW-1:0]   cmd_op;
  logic [CmdSlotW-1:0] cmd_slot;
  logic [CmdTW-1:0]    cmd_t;
  logic                unused_cmd;

  assign cmd_op     = cmd[CmdOpLsb +: CmdOpW];
  assign cmd_slot   = cmd[CmdSlotLsb +: CmdSlotW];
  assign cmd_t      = cmd[CmdTLsb +: CmdTW];
  assign unused_cmd = ^cmd[21:8];

  assign in_ready   = (state_q == StLoad);
  assign core_start = (state_q == StStart);
  assign done       = (state_q == StDone);
  assign load_fire  = in_ready & in_valid;
  assign err        = err_q;
  assign core_t     = core_t_q;
  assign operands   = ops_q;
  assign leds       = {err_q, state_q};

  rsa_result_serializer #(
    .OPW  (OPW),
    .BUSW (BUSW)
  ) u_ser (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (ser_clear),
    .active_i    (state_q == StUnload),
    .result_i    (result_q),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .last_o      (ser_last)
  );

  // Slot write demux: one BUSW chunk of the selected slot per accepted input beat.
  always_comb begin
    ops_d = ops_q;
    if (load_fire) ops_d[slot_q][ld_beat_q] = in_data;
  end

  // Command decode and transfer sequencing.
  always_comb begin
    state_d   = state_q;
    ld_beat_d = ld_beat_q;
    slot_d    = slot_q;
    result_d  = result_q;
    core_t_d  = core_t_q;
    err_d     = err_q;
    ser_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          err_d = 1'b0;
          case (cmd_op)
            OP_COMPUTE: begin
              core_t_d = TW'(cmd_t);
              state_d  = StStart;
            end
            OP_LOAD: begin
              if ({28'd0, cmd_slot} < NSLOT) begin
                slot_d    = SlotW'(cmd_slot);
                ld_beat_d = '0;
                state_d   = StLoad;
              end else begin
                err_d   = 1'b1;
                state_d = StDone;
              end
            end
            OP_READ: begin
              ser_clear = 1'b1;
              state_d   = StUnload;
            end
            default: begin
              err_d   = 1'b1;
              state_d = StDone;
            end
          endcase
        end
      end
      StLoad: begin
        if (load_fire) begin
          if (ld_beat_q == BeatW'(NBeat - 1)) begin
            ld_beat_d = '0;
            state_d   = StDone;
          end else begin
            ld_beat_d = ld_beat_q + 1'b1;
          end
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (core_done) begin
          result_d = core_result;
          state_d  = StDone;
        end
      end
      StUnload: begin
        if (ser_last) state_d = StDone;
      end
      StDone: begin
        if (done_read) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ld_beat_q <= '0;
      slot_q    <= '0;
      ops_q     <= '0;
      result_q  <= '0;
      core_t_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_beat_q <= ld_beat_d;
      slot_q    <= slot_d;
      ops_q     <= ops_d;
      result_q  <= result_d;
      core_t_q  <= core_t_d;
      err_q     <= err_d;
    end
  end

endmodule
